// File: rtl/coin_pulse_gen_pkg.sv
// Shared constants and types for the coin front end and the refund vending FSM.
// Coin values are expressed in 0.5-yuan units.
package coin_pulse_gen_pkg;

  localparam int unsigned CNT_MAX_DEF = 999_999;
  localparam int unsigned CNT_W_DEF   = 20;

  localparam int unsigned COIN_HALF = 1;
  localparam int unsigned COIN_ONE  = 2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ONE  = 2'd1,
    GNT_HALF = 2'd2
  } grant_e;

  function automatic int unsigned grant_value(input grant_e g);
    case (g)
      GNT_ONE:  grant_value = COIN_ONE;
      GNT_HALF: grant_value = COIN_HALF;
      default:  grant_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/coin_key_filter.sv
// One coin sensor channel: two-flop synchroniser plus saturating debounce counter.
// flag_o fires for one cycle when a low run reaches CNT_MAX samples.
module coin_key_filter
  import coin_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic flag_o
);

  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(CNT_MAX - 1);

  logic             key_s1_q;
  logic             key_s2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Syncs reset high so a key held low through reset is seen as a fresh press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      key_s1_q <= key_i;
      key_s2_q <= key_s1_q;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (key_s2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Saturation at CNT_MAX keeps a long hold from ever matching CNT_FIRE twice.
  assign flag_o = ~key_s2_q && (cnt_q == CNT_FIRE);

endmodule

// File: rtl/coin_pulse_gen.sv
// Debounces both coin sensors and emits one single-cycle pulse per accepted coin.
// The two outputs are mutually exclusive; 1-yuan wins and a losing half coin waits one cycle.
module coin_pulse_gen
  import coin_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_MAX = CNT_MAX_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_one,
  input  logic key_half,
  output logic po_money_one,
  output logic po_money_half
);

  logic   flag_one;
  logic   flag_half;
  logic   req_one;
  logic   req_half;
  grant_e grant;

  logic   pend_one_q;
  logic   pend_one_d;
  logic   pend_half_q;
  logic   pend_half_d;
  logic   po_one_q;
  logic   po_one_d;
  logic   po_half_q;
  logic   po_half_d;

  coin_key_filter #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_filter_one (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .key_i  (key_one),
    .flag_o (flag_one)
  );

  coin_key_filter #(
    .CNT_MAX (CNT_MAX),
    .CNT_W   (CNT_W)
  ) u_filter_half (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .key_i  (key_half),
    .flag_o (flag_half)
  );

  assign req_one  = flag_one  | pend_one_q;
  assign req_half = flag_half | pend_half_q;

  // A channel flags at most once per CNT_MAX+1 cycles, so one pending bit never overflows.
  always_comb begin
    grant       = GNT_NONE;
    pend_one_d  = pend_one_q;
    pend_half_d = pend_half_q;
    if (req_one) begin
      grant       = GNT_ONE;
      pend_one_d  = 1'b0;
      pend_half_d = req_half;
    end else if (req_half) begin
      grant       = GNT_HALF;
      pend_half_d = 1'b0;
    end
  end

  assign po_one_d  = (grant == GNT_ONE);
  assign po_half_d = (grant == GNT_HALF);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_one_q  <= 1'b0;
      pend_half_q <= 1'b0;
      po_one_q    <= 1'b0;
      po_half_q   <= 1'b0;
    end else begin
      pend_one_q  <= pend_one_d;
      pend_half_q <= pend_half_d;
      po_one_q    <= po_one_d;
      po_half_q   <= po_half_d;
    end
  end

  assign po_money_one  = po_one_q;
  assign po_money_half = po_half_q;

endmodule
